ro_puf_eval: RTL and testbench

RO_PUF_EVAL -- requirements
Module: ro_puf_eval

---
 rtl/ro_puf_eval.sv | 187 ++++++++++++++++++
 tb/tb_ro_puf_eval.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_eval.sv
// ro_puf_eval
//   Ring-oscillator PUF evaluator. For each response bit k, two oscillators
//   are selected from the challenge bases. Each oscillator's rising edges are
//   counted over a window of win_len clk cycles, and the response bit records
//   which oscillator was faster.
// Ports
//   clk      : system clock, all state on the rising edge
//   rst_n    : asynchronous reset, active high
//   ro_in    : free-running oscillator outputs, asynchronous to clk
//   start    : evaluation request, sampled only while idle
//   chal_a/b : base oscillator indices for the A and B sides
//   win_len  : measurement window in clk cycles (0 behaves as 1)
//   ro_en    : oscillator enable, high only while measuring
//   busy     : evaluation in progress
//   done     : one-cycle completion pulse
//   response : PUF response word
//   tie      : sticky, some bit saw equal counts
//   sat      : sticky, some counter saturated
module ro_puf_eval #(
  parameter int N_RO      = 32,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 12,
  parameter int RESP_BITS = 8,
  localparam int SEL_W    = $clog2(N_RO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_RO-1:0]      ro_in,
  input  logic                 start,
  input  logic [SEL_W-1:0]     chal_a,
  input  logic [SEL_W-1:0]     chal_b,
  input  logic [WIN_W-1:0]     win_len,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie,
  output logic                 sat
);

  localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [KW-1:0]    LAST_BIT = KW'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_TOP - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_chal_a;
  logic [SEL_W-1:0]   r_chal_b;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_win_cnt;
  logic               r_settle;
  logic [KW-1:0]      r_bit;
  logic               r_sa1, r_sa2, r_sa3;
  logic               r_sb1, r_sb2, r_sb3;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;

  logic [SEL_W-1:0]   w_sel_a;
  logic [SEL_W-1:0]   w_sel_b_raw;
  logic [SEL_W-1:0]   w_sel_b;
  logic               w_counting;

  // Power-of-two N_RO makes the SEL_W-bit truncation the modulo wrap.
  // A pair that collides on one oscillator is split onto its neighbour.
  always_comb begin
    w_sel_a     = r_chal_a + SEL_W'(r_bit);
    w_sel_b_raw = r_chal_b + SEL_W'(r_bit);
    w_sel_b     = (w_sel_b_raw == w_sel_a) ? (w_sel_a + SEL_W'(1)) : w_sel_b_raw;
    w_counting  = (r_state == S_MEASURE) || (r_state == S_SETTLE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= S_IDLE;
      r_chal_a  <= '0;
      r_chal_b  <= '0;
      r_win     <= '0;
      r_win_cnt <= '0;
      r_settle  <= 1'b0;
      r_bit     <= '0;
      r_sa1     <= 1'b0;
      r_sa2     <= 1'b0;
      r_sa3     <= 1'b0;
      r_sb1     <= 1'b0;
      r_sb2     <= 1'b0;
      r_sb3     <= 1'b0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= '0;
      tie       <= 1'b0;
      sat       <= 1'b0;
    end else begin
      done <= 1'b0;

      // Synchronizers keep shifting through SETTLE so edges still in flight
      // when the window closes are counted.
      if (w_counting) begin
        r_sa1 <= ro_in[w_sel_a];
        r_sa2 <= r_sa1;
        r_sa3 <= r_sa2;
        r_sb1 <= ro_in[w_sel_b];
        r_sb2 <= r_sb1;
        r_sb3 <= r_sb2;
        if (r_sa2 && !r_sa3 && (r_cnt_a != CNT_TOP)) begin
          r_cnt_a <= r_cnt_a + 1'b1;
          if (r_cnt_a == CNT_PRE) sat <= 1'b1;
        end
        if (r_sb2 && !r_sb3 && (r_cnt_b != CNT_TOP)) begin
          r_cnt_b <= r_cnt_b + 1'b1;
          if (r_cnt_b == CNT_PRE) sat <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal_a <= chal_a;
            r_chal_b <= chal_b;
            r_win    <= (win_len == '0) ? WIN_W'(1) : win_len;
            response <= '0;
            tie      <= 1'b0;
            sat      <= 1'b0;
            r_bit    <= '0;
            busy     <= 1'b1;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_sa1     <= 1'b0;
          r_sa2     <= 1'b0;
          r_sa3     <= 1'b0;
          r_sb1     <= 1'b0;
          r_sb2     <= 1'b0;
          r_sb3     <= 1'b0;
          r_cnt_a   <= '0;
          r_cnt_b   <= '0;
          r_win_cnt <= r_win;
          ro_en     <= 1'b1;
          r_state   <= S_MEASURE;
        end
        S_MEASURE: begin
          r_win_cnt <= r_win_cnt - 1'b1;
          if (r_win_cnt == WIN_W'(1)) begin
            ro_en    <= 1'b0;
            r_settle <= 1'b0;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_settle <= 1'b1;
          if (r_settle) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          response[r_bit] <= (r_cnt_a > r_cnt_b);
          if (r_cnt_a == r_cnt_b) tie <= 1'b1;
          if (r_bit == LAST_BIT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bit   <= r_bit + 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval
//   Randomized and directed bench for ro_puf_eval. Oscillators are modelled
//   as square waves with a per-input half period and phase, expressed as a
//   function of the clk cycle index. The reference counts rising transitions
//   of each selected oscillator over the samples taken during the window.
//   A second instance with a narrow counter exercises saturation.
module tb_ro_puf_eval;

  localparam int N   = 8;
  localparam int R   = 4;
  localparam int CW  = 8;
  localparam int CWS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [N-1:0] ro_in;
  logic       start;
  logic [2:0] chal_a, chal_b;
  logic [7:0] win_len;

  logic       ro_en, busy, done, tie, sat;
  logic [R-1:0] response;
  logic       s_ro_en, s_busy, s_done, s_tie, s_sat;
  logic [R-1:0] s_response;

  ro_puf_eval #(.N_RO(N), .CNT_W(CW), .WIN_W(8), .RESP_BITS(R)) u_dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start),
    .chal_a(chal_a), .chal_b(chal_b), .win_len(win_len),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response),
    .tie(tie), .sat(sat)
  );

  ro_puf_eval #(.N_RO(N), .CNT_W(CWS), .WIN_W(8), .RESP_BITS(R)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start),
    .chal_a(chal_a), .chal_b(chal_b), .win_len(win_len),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .response(s_response),
    .tie(s_tie), .sat(s_sat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hp[N];
  int ph[N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ro_val(input int i, input int c);
    return ((c + ph[i]) / hp[i]) % 2;
  endfunction

  // Value presented on ro_in during cycle index cyc, sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) ro_in[i] = (ro_val(i, cyc) != 0);
  endtask

  function automatic int rises(input int ro, input int first, input int w);
    int n = 0;
    int prev = 0;
    for (int i = 0; i < w; i++) begin
      int v = ro_val(ro, first + i);
      if (v != 0 && prev == 0) n++;
      prev = v;
    end
    return n;
  endfunction

  // Reference result of one evaluation accepted at sample index c0.
  function automatic void model(input int cmax, input int ca, input int cb, input int w,
                                input int c0, output logic [R-1:0] resp,
                                output logic t, output logic s);
    resp = '0;
    t = 1'b0;
    s = 1'b0;
    for (int k = 0; k < R; k++) begin
      int a = (ca + k) % N;
      int b = (cb + k) % N;
      int first = c0 + 2 + k * (w + 4);
      int na, nb;
      if (a == b) b = (a + 1) % N;
      na = rises(a, first, w);
      nb = rises(b, first, w);
      if (na >= cmax) begin s = 1'b1; na = cmax; end
      if (nb >= cmax) begin s = 1'b1; nb = cmax; end
      if (na > nb) resp[k] = 1'b1;
      else if (na == nb) t = 1'b1;
    end
  endfunction

  task automatic set_ro(input int base_hp, input int fast_idx, input int fast_hp);
    for (int i = 0; i < N; i++) begin
      hp[i] = (i == fast_idx) ? fast_hp : base_hp;
      ph[i] = 0;
    end
  endtask

  task automatic run_eval(input string tag, input int ca, input int cb, input int wl,
                          input bit noise);
    int w = (wl == 0) ? 1 : wl;
    int c0 = cyc;
    int lat = -1;
    int ndone = 0;
    int bad_busy = 0;
    int budget = R * (w + 4) + 20;
    logic [R-1:0] e_resp, es_resp;
    logic e_tie, e_sat, es_tie, es_sat;

    model((1 << CW) - 1, ca, cb, w, c0, e_resp, e_tie, e_sat);
    model((1 << CWS) - 1, ca, cb, w, c0, es_resp, es_tie, es_sat);

    chal_a  = 3'(ca);
    chal_b  = 3'(cb);
    win_len = 8'(wl);
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (done) ndone++;
    check_eq({tag, ".busy_after_start"}, 32'(busy), 32'd1);

    for (int i = 0; i < budget && lat < 0; i++) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        chal_a  = 3'($urandom);
        chal_b  = 3'($urandom);
        win_len = 8'($urandom);
      end
      tick();
      if (done) begin
        ndone++;
        lat = cyc - c0;
        if (busy) bad_busy++;
      end else if (!busy) begin
        bad_busy++;
      end
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(R * (w + 4) + 1));
    check_eq({tag, ".busy_window"}, 32'(bad_busy), 32'd0);

    // A request in the done cycle must be dropped.
    start  = 1'b1;
    chal_a = 3'($urandom);
    tick();
    start = 1'b0;
    if (done) ndone++;
    check_eq({tag, ".start_in_done_busy"}, 32'(busy), 32'd0);
    tick();
    if (done) ndone++;
    check_eq({tag, ".idle_after_done"}, 32'(busy), 32'd0);
    check_eq({tag, ".done_count"}, 32'(ndone), 32'd1);

    check_eq({tag, ".response"}, 32'(response), 32'(e_resp));
    check_eq({tag, ".tie"}, 32'(tie), 32'(e_tie));
    check_eq({tag, ".sat"}, 32'(sat), 32'(e_sat));
    check_eq({tag, ".n_response"}, 32'(s_response), 32'(es_resp));
    check_eq({tag, ".n_tie"}, 32'(s_tie), 32'(es_tie));
    check_eq({tag, ".n_sat"}, 32'(s_sat), 32'(es_sat));
  endtask

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    chal_a  = '0;
    chal_b  = '0;
    win_len = '0;
    set_ro(4, 0, 4);
    for (int i = 0; i < N; i++) ro_in[i] = (ro_val(i, cyc) != 0);
    repeat (3) tick();

    check_eq("rst.ro_en", 32'(ro_en), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.response", 32'(response), 32'd0);
    check_eq("rst.tie", 32'(tie), 32'd0);
    check_eq("rst.sat", 32'(sat), 32'd0);

    // Release mid-cycle; the very next edge must accept start.
    rst_n = 1'b0;

    set_ro(4, 0, 2);
    run_eval("fast0", 0, 1, 64, 1'b0);

    set_ro(4, 0, 4);
    run_eval("all_equal", 0, 1, 64, 1'b0);

    set_ro(4, 3, 2);
    run_eval("same_chal", 3, 3, 64, 1'b0);

    set_ro(4, 0, 2);
    run_eval("saturate", 0, 1, 255, 1'b0);

    // Reset during the measurement window of bit 2.
    set_ro(4, 0, 2);
    chal_a  = 3'd0;
    chal_b  = 3'd1;
    win_len = 8'd64;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * 68 + 10) tick();
    check_eq("midrst.ro_en_before", 32'(ro_en), 32'd1);
    check_eq("midrst.resp_before", 32'(response), 32'd1);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("midrst.ro_en", 32'(ro_en), 32'd0);
    check_eq("midrst.busy", 32'(busy), 32'd0);
    check_eq("midrst.response", 32'(response), 32'd0);
    check_eq("midrst.done", 32'(done), 32'd0);
    #1;
    rst_n = 1'b0;
    run_eval("after_rst", 0, 1, 64, 1'b0);

    set_ro(4, 0, 2);
    run_eval("noisy_start", 0, 1, 64, 1'b1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        hp[i] = int'($urandom_range(1, 6));
        ph[i] = int'($urandom_range(0, 11));
      end
      run_eval($sformatf("rand%0d", t), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 40)), t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
